// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings and a small elaboration-time helper.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mthi  = 4'd5,
    MDU_mtlo  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at start, parked in shadow registers and committed when busy ends.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_sh_hi;
  logic [WIDTH-1:0] r_sh_lo;

  mdu_state_e       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic [WIDTH-1:0] w_sh_hi_next;
  logic [WIDTH-1:0] w_sh_lo_next;

  mdu_op_e                w_op;
  logic signed [W2-1:0]   w_a_s;
  logic signed [W2-1:0]   w_b_s;
  logic        [W2-1:0]   w_a_u;
  logic        [W2-1:0]   w_b_u;
  logic signed [W2-1:0]   w_prod_s;
  logic        [W2-1:0]   w_prod_u;
  logic        [WIDTH-1:0] w_quot_s;
  logic        [WIDTH-1:0] w_rem_s;
  logic        [WIDTH-1:0] w_quot_u;
  logic        [WIDTH-1:0] w_rem_u;
  logic                   w_div_zero;

  assign w_op  = mdu_op_e'(MDUOp);
  assign w_a_s = {{WIDTH{A[WIDTH-1]}}, A};
  assign w_b_s = {{WIDTH{B[WIDTH-1]}}, B};
  assign w_a_u = {{WIDTH{1'b0}}, A};
  assign w_b_u = {{WIDTH{1'b0}}, B};

  // Widening to 2*WIDTH makes MIN / -1 fall out naturally as LO=MIN, HI=0.
  assign w_prod_s   = w_a_s * w_b_s;
  assign w_prod_u   = w_a_u * w_b_u;
  assign w_div_zero = (B == '0);
  assign w_quot_s   = w_div_zero ? '0 : WIDTH'(w_a_s / w_b_s);
  assign w_rem_s    = w_div_zero ? '0 : WIDTH'(w_a_s % w_b_s);
  assign w_quot_u   = w_div_zero ? '0 : WIDTH'(w_a_u / w_b_u);
  assign w_rem_u    = w_div_zero ? '0 : WIDTH'(w_a_u % w_b_u);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_sh_hi_next = r_sh_hi;
    w_sh_lo_next = r_sh_lo;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            MDU_mult: begin
              w_sh_hi_next = w_prod_s[W2-1:WIDTH];
              w_sh_lo_next = w_prod_s[WIDTH-1:0];
              w_cnt_next   = CNT_W'(MULT_CYCLES);
              w_state_next = ST_BUSY;
            end
            MDU_multu: begin
              w_sh_hi_next = w_prod_u[W2-1:WIDTH];
              w_sh_lo_next = w_prod_u[WIDTH-1:0];
              w_cnt_next   = CNT_W'(MULT_CYCLES);
              w_state_next = ST_BUSY;
            end
            // Divide by zero still occupies the unit but commits the old HI/LO.
            MDU_div: begin
              w_sh_hi_next = w_div_zero ? r_hi : w_rem_s;
              w_sh_lo_next = w_div_zero ? r_lo : w_quot_s;
              w_cnt_next   = CNT_W'(DIV_CYCLES);
              w_state_next = ST_BUSY;
            end
            MDU_divu: begin
              w_sh_hi_next = w_div_zero ? r_hi : w_rem_u;
              w_sh_lo_next = w_div_zero ? r_lo : w_quot_u;
              w_cnt_next   = CNT_W'(DIV_CYCLES);
              w_state_next = ST_BUSY;
            end
            MDU_mthi: w_hi_next = A;
            MDU_mtlo: w_lo_next = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = ST_IDLE;
          w_hi_next    = r_sh_hi;
          w_lo_next    = r_sh_lo;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_sh_hi <= w_sh_hi_next;
      r_sh_lo <= w_sh_lo_next;
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: vector table plus hand-written sequences
// for start-while-busy and reset corner cases, checked through a scoreboard queue.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   MDUOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  always #5 clk = ~clk;

  mdu_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .MDUOp(MDUOp),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  typedef struct {
    logic        go;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[19];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one op, optionally injects a second start on busy cycle inj_cyc,
  // then compares HI/LO/busy length with the scoreboard entry.
  task automatic run_op(input logic go, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ecyc, input int inj_cyc, input logic [3:0] inj_op,
                        input logic [31:0] inj_a);
    exp_t        e;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int          cyc;
    logic        hold_ok;
    sb.push_back('{hi: ehi, lo: elo, cycles: ecyc});
    @(negedge clk);
    start   = go;
    MDUOp   = op;
    A       = a;
    B       = b;
    prev_hi = HI;
    prev_lo = LO;
    @(negedge clk);
    start   = 1'b0;
    MDUOp   = 4'd0;
    A       = '0;
    B       = '0;
    cyc     = 0;
    hold_ok = 1'b1;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (HI !== prev_hi || LO !== prev_lo) hold_ok = 1'b0;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        MDUOp = inj_op;
        A     = inj_a;
        B     = 32'd3;
      end else begin
        start = 1'b0;
        MDUOp = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    MDUOp = 4'd0;
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d: go=%0b op=%0d A=0x%08h B=0x%08h -> HI=0x%08h LO=0x%08h busy_cycles=%0d",
             n_txn, go, op, a, b, HI, LO, cyc);
    check("busy_cycles", 32'(cyc), 32'(e.cycles));
    check("hold_during_busy", 32'(hold_ok), 32'd1);
    check("HI", HI, e.hi);
    check("LO", LO, e.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, MDU_mult,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{1'b1, MDU_multu, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{1'b1, MDU_div,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{1'b1, MDU_divu,  32'h7,        32'h2,        32'h1,        32'h3,        10};
    vecs[4]  = '{1'b1, MDU_mthi,  32'h11,       32'h0,        32'h11,       32'h3,        0};
    vecs[5]  = '{1'b1, MDU_mtlo,  32'h22,       32'h0,        32'h11,       32'h22,       0};
    vecs[6]  = '{1'b1, MDU_div,   32'h5,        32'h0,        32'h11,       32'h22,       10};
    vecs[7]  = '{1'b1, MDU_divu,  32'h5,        32'h0,        32'h11,       32'h22,       10};
    vecs[8]  = '{1'b0, MDU_mthi,  32'hDEAD,     32'h0,        32'h11,       32'h22,       0};
    vecs[9]  = '{1'b1, MDU_none,  32'h123,      32'h1,        32'h11,       32'h22,       0};
    vecs[10] = '{1'b1, 4'hF,      32'h77,       32'h1,        32'h11,       32'h22,       0};
    vecs[11] = '{1'b1, 4'h7,      32'h77,       32'h1,        32'h11,       32'h22,       0};
    vecs[12] = '{1'b1, MDU_div,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    vecs[13] = '{1'b1, MDU_div,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
    vecs[14] = '{1'b1, MDU_div,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3,        10};
    vecs[15] = '{1'b1, MDU_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
    vecs[16] = '{1'b1, MDU_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        5};
    vecs[17] = '{1'b1, MDU_divu,  32'hFFFFFFFF, 32'hA,        32'h5,        32'h19999999, 10};
    vecs[18] = '{1'b1, MDU_mult,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};

    reset = 1'b1;
    start = 1'b0;
    MDUOp = 4'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_HI", HI, 32'h0);
    check("reset_LO", LO, 32'h0);

    for (int i = 0; i < 19; i++)
      run_op(vecs[i].go, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cycles, 0, 4'd0, 32'h0);

    // Starts arriving while busy, including on the final busy cycle, must be ignored.
    run_op(1'b1, MDU_mult, 32'd6,   32'd7, 32'h0, 32'd42, 5,  2, MDU_mtlo, 32'h55);
    run_op(1'b1, MDU_mult, 32'd2,   32'd3, 32'h0, 32'd6,  5,  5, MDU_mthi, 32'h99);
    run_op(1'b1, MDU_div,  32'd100, 32'd7, 32'd2, 32'd14, 10, 4, MDU_div,  32'h1000);
    run_op(1'b1, MDU_divu, 32'd9,   32'd4, 32'd1, 32'd2,  10, 10, MDU_mult, 32'h7);

    // Reset wins over a simultaneous mthi.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    MDUOp = MDU_mthi;
    A     = 32'h77;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    MDUOp = 4'd0;
    check("reset_prio_HI", HI, 32'h0);
    check("reset_prio_LO", LO, 32'h0);
    check("reset_prio_busy", 32'(busy), 32'd0);

    // Abort a mult on its third busy cycle; nothing may be committed later.
    run_op(1'b1, MDU_mthi, 32'hAB, 32'h0, 32'hAB, 32'h0, 0, 0, 4'd0, 32'h0);
    @(negedge clk);
    start = 1'b1;
    MDUOp = MDU_mult;
    A     = 32'd9;
    B     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_HI", HI, 32'h0);
    check("abort_LO", LO, 32'h0);
    repeat (6) @(negedge clk);
    check("abort_no_late_LO", LO, 32'h0);
    run_op(1'b1, MDU_mult, 32'd3, 32'd4, 32'h0, 32'd12, 5, 0, 4'd0, 32'h0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; SHALL be even and at least 8.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration for mult/multu; SHALL be at least 1.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration for div/divu; SHALL be at least 1.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 reset  in  1: reset is synchronous and active-high.
REQ-006 start  in  1: qualifies MDUOp for one cycle.
REQ-007 MDUOp  in  4: operation code (none, mult, multu, div, divu, mthi, mtlo).
REQ-008 A  in  WIDTH: operand A (dividend / multiplicand / mthi-mtlo source).
REQ-009 B  in  WIDTH: operand B (divisor / multiplier).
REQ-010 busy  out  1: a multi-cycle operation is in progress.
REQ-011 HI  out  WIDTH: architectural HI register.
REQ-012 LO  out  WIDTH: architectural LO register.

Function
REQ-013 The unit SHALL have two states, IDLE and BUSY, plus a down-counter of at least clog2(max(MULT_CYCLES, DIV_CYCLES)+1) bits.
REQ-014 In IDLE, start=1 with mult/multu/div/divu SHALL latch the result into shadow registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the next edge.
REQ-015 busy SHALL be 1 for exactly N cycles, where N is the selected cycle count, starting the cycle after the start edge.
REQ-016 HI and LO SHALL update from the shadow registers at the edge that ends the last busy cycle, so the new values are visible in the same cycle busy reads 0.
REQ-017 HI and LO SHALL hold their previous values throughout BUSY.
REQ-018 mult: {HI,LO} SHALL be the signed 2*WIDTH product; multu SHALL be the unsigned product.
REQ-019 div: LO SHALL be the signed quotient truncated toward zero, and HI the remainder with the sign of the dividend.
REQ-020 divu: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-021 Signed MIN / -1 SHALL give LO = MIN and HI = 0, with no other effect.
REQ-022 Division with B == 0 SHALL still run busy for DIV_CYCLES, and HI and LO SHALL remain unchanged afterwards.
REQ-023 mthi/mtlo with start=1 in IDLE SHALL write A to HI/LO at the next edge with no busy cycle.
REQ-024 Any start asserted while busy=1 SHALL be ignored completely.
REQ-025 MDUOp none, or any undefined code, SHALL have no effect.
REQ-026 start=0 SHALL have no effect regardless of MDUOp.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, busy=0, HI=0, LO=0, counter=0 and shadow registers=0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset mid-operation SHALL abort the operation with no HI/LO commit.
REQ-030 The first start accepted after reset deasserts SHALL behave normally.

Structure
REQ-031 MDU op codes (MDU_none, MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mthi, MDU_mtlo) SHALL live in the shared definitions include next to the ALU op codes.
REQ-032 The state encodings SHALL live in that same shared include.
REQ-033 The block SHALL be a single module; no sub-module is required.
REQ-034 Arithmetic SHALL use behavioural operators on 2*WIDTH-bit signed/unsigned casts.

Verification
REQ-035 Scenario: WIDTH=32; mult A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 Scenario: div A=-7, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-037 Scenario: set HI=0x11, LO=0x22 via mthi/mtlo (no busy), then div A=5, B=0 -> busy 10 cycles, and HI=0x11, LO=0x22 are unchanged.
REQ-038 Scenario: div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 Scenario: during mult busy, start mtlo A=0x55 -> ignored, LO equals the product after busy falls.
REQ-040 Scenario: reset on busy cycle 3 of mult -> busy=0, HI=LO=0; then mult 3*4 -> LO=12 after 5 cycles.
